// File: rtl/dmg_clk_pkg.sv
// Shared definitions for the raw-oscillator reset/STOP sequencer:
// state encoding, default timing parameters and a clog2 helper.
package dmg_clk_pkg;

  typedef enum logic [2:0] {
    ST_HOLD = 3'd0,
    ST_WAIT = 3'd1,
    ST_RUN  = 3'd2,
    ST_STOP = 3'd3,
    ST_WAKE = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_RESET_HOLD  = 8;
  localparam int unsigned DEF_STABLE_BITS = 16;

  typedef struct packed {
    logic soc_reset;
    logic osc_ena;
    logic osc_stable;
    logic clk_ena;
  } seq_out_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Output levels held while resident in a state; illegal codes map to reset levels.
  function automatic seq_out_t state_outputs(input seq_state_e s);
    seq_out_t o;
    case (s)
      ST_RUN:  o = '{soc_reset: 1'b0, osc_ena: 1'b1, osc_stable: 1'b1, clk_ena: 1'b1};
      ST_STOP: o = '{soc_reset: 1'b0, osc_ena: 1'b0, osc_stable: 1'b0, clk_ena: 1'b0};
      ST_WAKE: o = '{soc_reset: 1'b0, osc_ena: 1'b1, osc_stable: 1'b0, clk_ena: 1'b0};
      default: o = '{soc_reset: 1'b1, osc_ena: 1'b1, osc_stable: 1'b0, clk_ena: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/osc_stab_counter.sv
// Clear/enable up-counter with an exact-match terminal flag; saturates
// rather than wrapping so a missed clear can never fake a terminal.
module osc_stab_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_cmp,
  output logic         o_term
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_term = (r_cnt == i_cmp);

endmodule

// File: rtl/osc_rst_seq.sv
// Power-on / STOP sequencer on the raw pad clock: holds reset, waits for
// oscillator settling, then enables ClkGen; handles STOP shutdown and wake.
module osc_rst_seq
  import dmg_clk_pkg::*;
#(
  parameter int unsigned RESET_HOLD  = DEF_RESET_HOLD,
  parameter int unsigned STABLE_BITS = DEF_STABLE_BITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stop_req,
  input  logic       wake,
  output logic       soc_reset,
  output logic       osc_ena,
  output logic       osc_stable,
  output logic       clk_ena,
  output logic [2:0] seq_state
);

  localparam int unsigned CNT_W =
    (STABLE_BITS > clog2(RESET_HOLD)) ? STABLE_BITS : clog2(RESET_HOLD);
  localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'({STABLE_BITS{1'b1}});

  seq_state_e   r_state;
  seq_state_e   w_nxt_state;
  seq_out_t     r_out;
  logic         w_cnt_clr;
  logic         w_cnt_en;
  logic         w_cnt_term;
  logic [CNT_W-1:0] w_cnt_cmp;

  osc_stab_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (reset),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .i_cmp  (w_cnt_cmp),
    .o_term (w_cnt_term)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_cnt_cmp   = SETTLE_TERM;
    case (r_state)
      ST_HOLD: begin
        w_cnt_cmp = HOLD_TERM;
        if (w_cnt_term) begin
          w_nxt_state = ST_WAIT;
          w_cnt_clr   = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_WAIT, ST_WAKE: begin
        if (w_cnt_term) begin
          w_nxt_state = ST_RUN;
          w_cnt_clr   = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_RUN: begin
        w_cnt_clr = 1'b1;
        if (stop_req) w_nxt_state = ST_STOP;
      end
      ST_STOP: begin
        // Counter is held clear here so WAKE always starts counting from zero.
        w_cnt_clr = 1'b1;
        if (wake) w_nxt_state = ST_WAKE;
      end
      default: begin
        w_nxt_state = ST_HOLD;
        w_cnt_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_HOLD;
      r_out   <= '{soc_reset: 1'b1, osc_ena: 1'b1, osc_stable: 1'b0, clk_ena: 1'b0};
    end else begin
      r_state <= w_nxt_state;
      r_out   <= state_outputs(w_nxt_state);
    end
  end

  assign soc_reset  = r_out.soc_reset;
  assign osc_ena    = r_out.osc_ena;
  assign osc_stable = r_out.osc_stable;
  assign clk_ena    = r_out.clk_ena;
  assign seq_state  = r_state;

endmodule

// File: tb/tb_osc_rst_seq.sv
// Randomized bench for osc_rst_seq against a countdown-based reference model
// (edges remaining until clocks run, plus boot/stopped flags).
module tb_osc_rst_seq;

  localparam int unsigned RH     = 8;
  localparam int unsigned SB     = 4;
  localparam int          SETTLE = 1 << SB;

  logic       clk = 1'b0;
  logic       reset;
  logic       stop_req;
  logic       wake;
  logic       soc_reset;
  logic       osc_ena;
  logic       osc_stable;
  logic       clk_ena;
  logic [2:0] seq_state;

  int n_checks = 0;
  int n_fail   = 0;

  int m_left;
  bit m_boot;
  bit m_stop;

  osc_rst_seq #(
    .RESET_HOLD  (RH),
    .STABLE_BITS (SB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stop_req   (stop_req),
    .wake       (wake),
    .soc_reset  (soc_reset),
    .osc_ena    (osc_ena),
    .osc_stable (osc_stable),
    .clk_ena    (clk_ena),
    .seq_state  (seq_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_left = RH + SETTLE;
    m_boot = 1'b1;
    m_stop = 1'b0;
  endfunction

  function automatic logic [7:0] m_state();
    if (m_boot) return (m_left > SETTLE) ? 8'd0 : 8'd1;
    if (m_stop) return 8'd3;
    if (m_left > 0) return 8'd4;
    return 8'd2;
  endfunction

  task automatic check_all(input string tag);
    bit running;
    running = (m_left == 0) && !m_stop;
    chk({tag, ".state"},      8'(seq_state),  m_state());
    chk({tag, ".soc_reset"},  8'(soc_reset),  8'(m_boot));
    chk({tag, ".osc_ena"},    8'(osc_ena),    8'(!m_stop));
    chk({tag, ".osc_stable"}, 8'(osc_stable), 8'(running));
    chk({tag, ".clk_ena"},    8'(clk_ena),    8'(running));
  endtask

  task automatic cycle(input string tag, input bit s, input bit w);
    stop_req = s;
    wake     = w;
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_boot = 1'b0;
    end else if (!m_stop) begin
      if (s) m_stop = 1'b1;
    end else if (w) begin
      m_stop = 1'b0;
      m_left = SETTLE;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  // Called while clk is low; checks the asynchronous effect before any edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    m_reset();
    check_all(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    stop_req = 1'b0;
    wake     = 1'b0;
    @(negedge clk);
    do_reset("reset");

    repeat (7) cycle("cold", 1'b0, 1'b0);
    chk("cold.edge7_state", 8'(seq_state), 8'd0);
    cycle("cold", 1'b0, 1'b0);
    chk("cold.edge8_state", 8'(seq_state), 8'd1);
    repeat (15) cycle("cold", 1'b0, 1'b0);
    chk("cold.edge23_clk_ena", 8'(clk_ena), 8'd0);
    cycle("cold", 1'b0, 1'b0);
    chk("cold.edge24_clk_ena", 8'(clk_ena), 8'd1);
    chk("cold.edge24_soc_reset", 8'(soc_reset), 8'd0);

    repeat (3) cycle("run_wake_ignored", 1'b0, 1'b1);
    cycle("stop", 1'b1, 1'b0);
    chk("stop.osc_ena", 8'(osc_ena), 8'd0);
    repeat (3) cycle("stopped", 1'b1, 1'b0);
    cycle("wake", 1'b0, 1'b1);
    chk("wake.osc_ena", 8'(osc_ena), 8'd1);
    repeat (15) cycle("waking", 1'b0, 1'b1);
    cycle("waking", 1'b0, 1'b0);
    chk("wake16.clk_ena", 8'(clk_ena), 8'd1);

    cycle("stop2", 1'b1, 1'b0);
    cycle("glitch", 1'b0, 1'b1);
    repeat (16) cycle("glitch_wake", 1'b0, 1'b0);
    chk("glitch.state", 8'(seq_state), 8'd2);

    cycle("simul", 1'b1, 1'b1);
    repeat (4) cycle("simul_hold", 1'b0, 1'b0);
    chk("simul.state", 8'(seq_state), 8'd3);

    cycle("wake3", 1'b0, 1'b1);
    repeat (7) cycle("wake3_cnt", 1'b0, 1'b0);
    do_reset("mid_wake_reset");
    repeat (24) cycle("restart_stop_ignored", 1'b1, 1'b0);
    chk("restart.edge24_state", 8'(seq_state), 8'd2);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rand_reset");
      end else begin
        cycle("rand", ($urandom % 6) == 0, ($urandom % 5) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
